axi_lite_cmd_manager: RTL and testbench
=======================================

Name: axi_lite_cmd_manager

Overview:
- AXI4-Lite manager (initiator) that turns a command stream into single register reads and writes on an AXI4-Lite bus.
- Sits upstream of the ADC configuration register block. Lets the PS DMA or the sequencer FPGA logic program cfg/dma/packetizer/trigger registers without CPU bus access.
- Each command produces exactly one response beat carrying read data and the bus response code.

Parameters:
TIMEOUT_CYCLES, 1024, cycles waiting on any AXI channel before the sticky timeout flag sets; 0 disables the flag.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axis_cmd_tdata  in  64  [63:32] address, [31:0] write data
s_axis_cmd_tuser  in  5  [0] rnw (1=read), [4:1] wstrb
s_axis_cmd_tvalid  in  1  command valid
s_axis_cmd_tready  out  1  command accept
m_axis_rsp_tdata  out  32  read data; 0 for writes
m_axis_rsp_tuser  out  2  AXI resp code (BRESP or RRESP)
m_axis_rsp_tvalid  out  1  response valid
m_axis_rsp_tready  in  1  response accept
m_axi_awaddr  out  32  write address
m_axi_awprot  out  3  constant 3'b000
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  byte strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  32  read address
m_axi_arprot  out  3  constant 3'b000
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
busy  out  1  high whenever state is not IDLE
timeout  out  1  sticky; cleared only by reset
err_count  out  16  saturating count of responses with resp != 2'b00

Behaviour:

Reset:
- All valid/ready outputs 0; addresses/data 0; busy 0; timeout 0; err_count 0; state IDLE.
- Asynchronous reset mid-transaction drops all valids immediately. No response beat is emitted for the aborted command.

Addressing:
- Address bits [1:0] are forced to 0 on awaddr/araddr.

FSM states: IDLE, WRITE, WRESP, READ, RDATA, RSP.

IDLE:
- s_axis_cmd_tready=1.
- On cmd handshake: latch address, data, wstrb.
- rnw=0 -> WRITE, with awvalid=1 and wvalid=1 registered for the next cycle.
- rnw=1 -> READ, with arvalid=1.
- Command-to-bus latency: 1 cycle.

WRITE:
- awvalid and wvalid drop independently on their own handshakes. Either order is legal, as is the same cycle.
- When both channels are done (including same-cycle completion) -> WRESP with bready=1.

WRESP:
- On bvalid&bready: capture bresp, rsp_tdata=0, bready=0 -> RSP.

READ:
- On arvalid&arready: arvalid=0, rready=1 -> RDATA.

RDATA:
- On rvalid&rready: capture rdata/rresp, rready=0 -> RSP.

RSP:
- m_axis_rsp_tvalid=1 and held, with data and resp held stable, until rsp_tready.
- On handshake: tvalid=0 -> IDLE.
- Bus-response-to-rsp_tvalid latency: 1 cycle.
- Command-to-command throughput: at minimum 4 cycles per write and 4 per read.

err_count:
- Increments by 1 in the cycle the B/R response with resp != 0 is captured.
- Saturates at 16'hFFFF.

Timeout:
- A wait counter resets on every state change. It increments while in WRITE, WRESP, READ or RDATA.
- When it reaches TIMEOUT_CYCLES, timeout sets. The transaction is NOT abandoned, to preserve AXI compliance.

Handshake and ordering rules:
- Valid signals never deassert before their handshake.
- No new command is accepted until the prior response is consumed. At most one outstanding transaction, strictly in order.

Test Plan:
- Write, slave ready always: cmd addr 0x0000_0004, data 0xDEAD_BEEF, wstrb 4'hF -> AW/W valid the cycle after accept; addr 0x04, data 0xDEADBEEF; bresp 0 -> rsp tdata 0, tuser 0; err_count 0.
- Read: cmd rnw=1, addr 0x0000_0013 -> araddr 0x0000_0010; slave returns rdata 0x1234_5678, rresp 0 -> rsp tdata 0x12345678, tuser 0, one cycle after the R handshake.
- Split write channels: awready held low 5 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid stays high until awready; exactly one B accepted, one rsp beat.
- Error response: slave returns rresp 2'b10 on read of 0x0000_0020 -> rsp tuser 2'b10; err_count 1; a following OKAY write leaves err_count 1.
- Backpressure: rsp_tready low 10 cycles -> rsp_tvalid and data stable; cmd_tready 0 for the whole period; next cmd accepted only after the rsp handshake.
- Timeout and reset: TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> timeout=1 from the 8th waiting cycle, bready stays 1. Then assert aresetn low mid-wait -> all valids 0, busy 0, timeout 0, no rsp beat.

Source files
------------

// File: rtl/axi_lite_cmd_manager_if.sv
// Command stream, response stream and AXI4-Lite manager bus for axi_lite_cmd_manager.
// The master modport is the manager's view; the slave modport is the far side (source, sink and register block).
interface axi_lite_cmd_manager_if;
   logic [63:0] s_axis_cmd_tdata;
   logic [4:0]  s_axis_cmd_tuser;
   logic        s_axis_cmd_tvalid;
   logic        s_axis_cmd_tready;

   logic [31:0] m_axis_rsp_tdata;
   logic [1:0]  m_axis_rsp_tuser;
   logic        m_axis_rsp_tvalid;
   logic        m_axis_rsp_tready;

   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   modport master (
      input  s_axis_cmd_tdata, s_axis_cmd_tuser, s_axis_cmd_tvalid,
      output s_axis_cmd_tready,
      output m_axis_rsp_tdata, m_axis_rsp_tuser, m_axis_rsp_tvalid,
      input  m_axis_rsp_tready,
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      output s_axis_cmd_tdata, s_axis_cmd_tuser, s_axis_cmd_tvalid,
      input  s_axis_cmd_tready,
      input  m_axis_rsp_tdata, m_axis_rsp_tuser, m_axis_rsp_tvalid,
      output m_axis_rsp_tready,
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/axi_lite_cmd_manager.sv
// Turns each command beat into one AXI4-Lite read or write and returns one response beat; command-to-bus and bus-to-response are 1 cycle each.
// One transaction in flight: cmd_tready stays low until the response is consumed; bus valids and rsp_tvalid hold until their handshakes.
module axi_lite_cmd_manager #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   axi_lite_cmd_manager_if.master       bus,
   output logic                         busy,
   output logic                         timeout,
   output logic [15:0]                  err_count
);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

   localparam int unsigned   CW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          bready_q, bready_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          rsp_vld_q, rsp_vld_d;
   logic [31:0]   rsp_dat_q, rsp_dat_d;
   logic [1:0]    rsp_resp_q, rsp_resp_d;
   logic [15:0]   err_count_q, err_count_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          timeout_q, timeout_d;

   logic          aw_done, w_done, err_inc, waiting;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_vld_d   = rsp_vld_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_resp_d  = rsp_resp_q;
      aw_done     = 1'b0;
      w_done      = 1'b0;
      err_inc     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_rdy_q && bus.s_axis_cmd_tvalid) begin
               addr_d  = {bus.s_axis_cmd_tdata[63:34], 2'b00};
               wdata_d = bus.s_axis_cmd_tdata[31:0];
               wstrb_d = bus.s_axis_cmd_tuser[4:1];
               if (bus.s_axis_cmd_tuser[0]) begin
                  state_d   = READ;
                  arvalid_d = 1'b1;
               end else begin
                  state_d   = WRITE;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end
            end
         end
         WRITE: begin
            // Each channel is done once its valid has already dropped or handshakes now.
            aw_done = !awvalid_q || bus.m_axi_awready;
            w_done  = !wvalid_q || bus.m_axi_wready;
            if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               state_d  = WRESP;
               bready_d = 1'b1;
            end
         end
         WRESP: begin
            if (bready_q && bus.m_axi_bvalid) begin
               bready_d   = 1'b0;
               rsp_dat_d  = 32'h0;
               rsp_resp_d = bus.m_axi_bresp;
               rsp_vld_d  = 1'b1;
               err_inc    = |bus.m_axi_bresp;
               state_d    = RSP;
            end
         end
         READ: begin
            if (arvalid_q && bus.m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (rready_q && bus.m_axi_rvalid) begin
               rready_d   = 1'b0;
               rsp_dat_d  = bus.m_axi_rdata;
               rsp_resp_d = bus.m_axi_rresp;
               rsp_vld_d  = 1'b1;
               err_inc    = |bus.m_axi_rresp;
               state_d    = RSP;
            end
         end
         RSP: begin
            if (bus.m_axis_rsp_tready) begin
               rsp_vld_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_rdy_d   = (state_d == IDLE);
      err_count_d = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;

      // The wait counter measures time spent in one bus-wait state only.
      waiting = (state_q == WRITE) || (state_q == WRESP) || (state_q == READ) || (state_q == RDATA);
      if (state_d != state_q)
         wait_cnt_d = '0;
      else if (waiting && (wait_cnt_q != '1))
         wait_cnt_d = wait_cnt_q + CW'(1);
      else
         wait_cnt_d = wait_cnt_q;
      timeout_d = timeout_q || ((TIMEOUT_CYCLES != 0) && waiting && (wait_cnt_q == TO_LAST));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         cmd_rdy_q   <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_dat_q   <= 32'h0;
         rsp_resp_q  <= 2'b00;
         err_count_q <= 16'h0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_rdy_q   <= cmd_rdy_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_resp_q  <= rsp_resp_d;
         err_count_q <= err_count_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.s_axis_cmd_tready = cmd_rdy_q;
   assign bus.m_axis_rsp_tdata  = rsp_dat_q;
   assign bus.m_axis_rsp_tuser  = rsp_resp_q;
   assign bus.m_axis_rsp_tvalid = rsp_vld_q;
   assign bus.m_axi_awaddr      = addr_q;
   assign bus.m_axi_awprot      = 3'b000;
   assign bus.m_axi_awvalid     = awvalid_q;
   assign bus.m_axi_wdata       = wdata_q;
   assign bus.m_axi_wstrb       = wstrb_q;
   assign bus.m_axi_wvalid      = wvalid_q;
   assign bus.m_axi_bready      = bready_q;
   assign bus.m_axi_araddr      = addr_q;
   assign bus.m_axi_arprot      = 3'b000;
   assign bus.m_axi_arvalid     = arvalid_q;
   assign bus.m_axi_rready      = rready_q;

   assign busy      = (state_q != IDLE);
   assign timeout   = timeout_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_axi_lite_cmd_manager.sv
// Directed bench for axi_lite_cmd_manager: writes, reads, split channels, error codes, backpressure, timeout and async reset.
module tb_axi_lite_cmd_manager;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        busy;
   logic        timeout;
   logic [15:0] err_count;
   int          total = 0;
   int          bad = 0;

   axi_lite_cmd_manager_if bus();

   axi_lite_cmd_manager #(.TIMEOUT_CYCLES(8)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .bus       (bus.master),
      .busy      (busy),
      .timeout   (timeout),
      .err_count (err_count)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input logic rnw);
      bus.s_axis_cmd_tdata  = {addr, data};
      bus.s_axis_cmd_tuser  = {strb, rnw};
      bus.s_axis_cmd_tvalid = 1'b1;
   endtask

   initial begin
      aresetn               = 1'b0;
      bus.s_axis_cmd_tdata  = 64'h0;
      bus.s_axis_cmd_tuser  = 5'h0;
      bus.s_axis_cmd_tvalid = 1'b0;
      bus.m_axis_rsp_tready = 1'b1;
      bus.m_axi_awready     = 1'b1;
      bus.m_axi_wready      = 1'b1;
      bus.m_axi_bresp       = 2'b00;
      bus.m_axi_bvalid      = 1'b0;
      bus.m_axi_arready     = 1'b1;
      bus.m_axi_rdata       = 32'h0;
      bus.m_axi_rresp       = 2'b00;
      bus.m_axi_rvalid      = 1'b0;

      // Reset state
      #2;
      check("rst_cmd_tready", {31'h0, bus.s_axis_cmd_tready}, 32'h0);
      check("rst_awvalid",    {31'h0, bus.m_axi_awvalid}, 32'h0);
      check("rst_arvalid",    {31'h0, bus.m_axi_arvalid}, 32'h0);
      check("rst_rsp_tvalid", {31'h0, bus.m_axis_rsp_tvalid}, 32'h0);
      check("rst_awaddr",     bus.m_axi_awaddr, 32'h0);
      check("rst_busy",       {31'h0, busy}, 32'h0);
      check("rst_timeout",    {31'h0, timeout}, 32'h0);
      check("rst_err_count",  {16'h0, err_count}, 32'h0);
      step();
      step();
      aresetn = 1'b1;
      step();
      check("idle_cmd_tready", {31'h0, bus.s_axis_cmd_tready}, 32'h1);

      // Plain write, slave always ready
      send_cmd(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("wr_awvalid",   {31'h0, bus.m_axi_awvalid}, 32'h1);
      check("wr_wvalid",    {31'h0, bus.m_axi_wvalid}, 32'h1);
      check("wr_awaddr",    bus.m_axi_awaddr, 32'h0000_0004);
      check("wr_wdata",     bus.m_axi_wdata, 32'hDEAD_BEEF);
      check("wr_wstrb",     {28'h0, bus.m_axi_wstrb}, 32'hF);
      check("wr_busy",      {31'h0, busy}, 32'h1);
      check("wr_cmd_tready",{31'h0, bus.s_axis_cmd_tready}, 32'h0);
      step();
      check("wr_aw_drop",   {31'h0, bus.m_axi_awvalid}, 32'h0);
      check("wr_w_drop",    {31'h0, bus.m_axi_wvalid}, 32'h0);
      check("wr_bready",    {31'h0, bus.m_axi_bready}, 32'h1);
      bus.m_axi_bvalid = 1'b1;
      bus.m_axi_bresp  = 2'b00;
      step();
      bus.m_axi_bvalid = 1'b0;
      check("wr_rsp_tvalid", {31'h0, bus.m_axis_rsp_tvalid}, 32'h1);
      check("wr_rsp_tdata",  bus.m_axis_rsp_tdata, 32'h0);
      check("wr_rsp_tuser",  {30'h0, bus.m_axis_rsp_tuser}, 32'h0);
      check("wr_bready_off", {31'h0, bus.m_axi_bready}, 32'h0);
      check("wr_err_count",  {16'h0, err_count}, 32'h0);
      step();
      check("wr_rsp_done",   {31'h0, bus.m_axis_rsp_tvalid}, 32'h0);
      check("wr_idle_rdy",   {31'h0, bus.s_axis_cmd_tready}, 32'h1);
      check("wr_idle_busy",  {31'h0, busy}, 32'h0);

      // Read with unaligned address
      send_cmd(32'h0000_0013, 32'h0, 4'h0, 1'b1);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("rd_arvalid", {31'h0, bus.m_axi_arvalid}, 32'h1);
      check("rd_araddr",  bus.m_axi_araddr, 32'h0000_0010);
      check("rd_awvalid", {31'h0, bus.m_axi_awvalid}, 32'h0);
      step();
      check("rd_ar_drop", {31'h0, bus.m_axi_arvalid}, 32'h0);
      check("rd_rready",  {31'h0, bus.m_axi_rready}, 32'h1);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'h1234_5678;
      bus.m_axi_rresp  = 2'b00;
      step();
      bus.m_axi_rvalid = 1'b0;
      check("rd_rsp_tvalid", {31'h0, bus.m_axis_rsp_tvalid}, 32'h1);
      check("rd_rsp_tdata",  bus.m_axis_rsp_tdata, 32'h1234_5678);
      check("rd_rsp_tuser",  {30'h0, bus.m_axis_rsp_tuser}, 32'h0);
      check("rd_rready_off", {31'h0, bus.m_axi_rready}, 32'h0);
      step();
      check("rd_idle_rdy",   {31'h0, bus.s_axis_cmd_tready}, 32'h1);

      // Split write channels: W completes first, AW stalls
      bus.m_axi_awready = 1'b0;
      send_cmd(32'h0000_0008, 32'h0000_0055, 4'h3, 1'b0);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("sp_awvalid", {31'h0, bus.m_axi_awvalid}, 32'h1);
      check("sp_wvalid",  {31'h0, bus.m_axi_wvalid}, 32'h1);
      check("sp_wstrb",   {28'h0, bus.m_axi_wstrb}, 32'h3);
      step();
      check("sp_w_drop",  {31'h0, bus.m_axi_wvalid}, 32'h0);
      check("sp_aw_hold", {31'h0, bus.m_axi_awvalid}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("sp_aw_wait", {31'h0, bus.m_axi_awvalid}, 32'h1);
         check("sp_no_bready", {31'h0, bus.m_axi_bready}, 32'h0);
      end
      bus.m_axi_awready = 1'b1;
      step();
      check("sp_aw_drop",  {31'h0, bus.m_axi_awvalid}, 32'h0);
      check("sp_bready",   {31'h0, bus.m_axi_bready}, 32'h1);
      check("sp_awaddr",   bus.m_axi_awaddr, 32'h0000_0008);
      check("sp_timeout",  {31'h0, timeout}, 32'h0);
      bus.m_axi_bvalid = 1'b1;
      step();
      bus.m_axi_bvalid = 1'b0;
      check("sp_rsp_tvalid", {31'h0, bus.m_axis_rsp_tvalid}, 32'h1);
      check("sp_bready_off", {31'h0, bus.m_axi_bready}, 32'h0);
      step();
      check("sp_one_beat",   {31'h0, bus.m_axis_rsp_tvalid}, 32'h0);

      // Error read response, then an OKAY write
      send_cmd(32'h0000_0020, 32'h0, 4'h0, 1'b1);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("er_araddr", bus.m_axi_araddr, 32'h0000_0020);
      step();
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'h0000_0BAD;
      bus.m_axi_rresp  = 2'b10;
      step();
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rresp  = 2'b00;
      check("er_rsp_tuser", {30'h0, bus.m_axis_rsp_tuser}, 32'h2);
      check("er_rsp_tdata", bus.m_axis_rsp_tdata, 32'h0000_0BAD);
      check("er_err_count", {16'h0, err_count}, 32'h1);
      step();
      send_cmd(32'h0000_0024, 32'h0000_0001, 4'hF, 1'b0);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      step();
      bus.m_axi_bvalid = 1'b1;
      bus.m_axi_bresp  = 2'b00;
      step();
      bus.m_axi_bvalid = 1'b0;
      check("ok_rsp_tuser", {30'h0, bus.m_axis_rsp_tuser}, 32'h0);
      check("ok_err_count", {16'h0, err_count}, 32'h1);
      step();

      // Response backpressure with the next command already waiting
      bus.m_axis_rsp_tready = 1'b0;
      send_cmd(32'h0000_0030, 32'h0, 4'h0, 1'b1);
      step();
      send_cmd(32'h0000_0040, 32'h0000_0077, 4'hF, 1'b0);
      step();
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hCAFE_F00D;
      step();
      bus.m_axi_rvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_tvalid", {31'h0, bus.m_axis_rsp_tvalid}, 32'h1);
         check("bp_rsp_tdata",  bus.m_axis_rsp_tdata, 32'hCAFE_F00D);
         check("bp_rsp_tuser",  {30'h0, bus.m_axis_rsp_tuser}, 32'h0);
         check("bp_cmd_tready", {31'h0, bus.s_axis_cmd_tready}, 32'h0);
         step();
      end
      bus.m_axis_rsp_tready = 1'b1;
      check("bp_timeout", {31'h0, timeout}, 32'h0);
      step();
      check("bp_rsp_done",  {31'h0, bus.m_axis_rsp_tvalid}, 32'h0);
      check("bp_cmd_ready", {31'h0, bus.s_axis_cmd_tready}, 32'h1);
      check("bp_not_yet",   {31'h0, bus.m_axi_awvalid}, 32'h0);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("bp_next_aw",   {31'h0, bus.m_axi_awvalid}, 32'h1);
      check("bp_next_addr", bus.m_axi_awaddr, 32'h0000_0040);
      check("bp_next_data", bus.m_axi_wdata, 32'h0000_0077);
      step();
      bus.m_axi_bvalid = 1'b1;
      step();
      bus.m_axi_bvalid = 1'b0;
      step();

      // Timeout while B is withheld, then reset mid-wait
      send_cmd(32'h0000_0050, 32'h0000_00AA, 4'hF, 1'b0);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      step();
      check("to_bready", {31'h0, bus.m_axi_bready}, 32'h1);
      step();
      step();
      step();
      check("to_early", {31'h0, timeout}, 32'h0);
      for (int i = 0; i < 6; i++) step();
      check("to_set",       {31'h0, timeout}, 32'h1);
      check("to_bready_on", {31'h0, bus.m_axi_bready}, 32'h1);
      check("to_busy",      {31'h0, busy}, 32'h1);
      for (int i = 0; i < 6; i++) step();
      check("to_sticky",    {31'h0, timeout}, 32'h1);
      aresetn = 1'b0;
      #1;
      check("ar_awvalid",   {31'h0, bus.m_axi_awvalid}, 32'h0);
      check("ar_wvalid",    {31'h0, bus.m_axi_wvalid}, 32'h0);
      check("ar_bready",    {31'h0, bus.m_axi_bready}, 32'h0);
      check("ar_arvalid",   {31'h0, bus.m_axi_arvalid}, 32'h0);
      check("ar_rready",    {31'h0, bus.m_axi_rready}, 32'h0);
      check("ar_rsp_tvalid",{31'h0, bus.m_axis_rsp_tvalid}, 32'h0);
      check("ar_busy",      {31'h0, busy}, 32'h0);
      check("ar_timeout",   {31'h0, timeout}, 32'h0);
      check("ar_err_count", {16'h0, err_count}, 32'h0);
      step();
      aresetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ar_no_rsp", {31'h0, bus.m_axis_rsp_tvalid}, 32'h0);
      end
      check("ar_ready_again", {31'h0, bus.s_axis_cmd_tready}, 32'h1);

      // Recovery read after reset
      send_cmd(32'h0000_0064, 32'h0, 4'h0, 1'b1);
      step();
      bus.s_axis_cmd_tvalid = 1'b0;
      check("rc_araddr", bus.m_axi_araddr, 32'h0000_0064);
      step();
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'h0BAD_F00D;
      bus.m_axi_rresp  = 2'b11;
      step();
      bus.m_axi_rvalid = 1'b0;
      check("rc_rsp_tdata", bus.m_axis_rsp_tdata, 32'h0BAD_F00D);
      check("rc_rsp_tuser", {30'h0, bus.m_axis_rsp_tuser}, 32'h3);
      check("rc_err_count", {16'h0, err_count}, 32'h1);
      step();
      check("rc_idle", {31'h0, busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
